// File: rtl/issue_dispatch_if.sv
// rtl/issue_dispatch_if.sv - decoder-to-issue and issue-to-station handshake bundle
interface issue_dispatch_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_alu_ctrl;
  logic [1:0]  in_imm_src;
  logic        in_imminstr;
  logic        in_load_en;
  logic        in_store_en;
  logic        in_add_en;
  logic        in_mul_en;

  logic        ld_valid;
  logic        st_valid;
  logic        add_valid;
  logic        mul_valid;
  logic        ld_ready;
  logic        st_ready;
  logic        add_ready;
  logic        mul_ready;

  logic [2:0]  iss_op;
  logic [4:0]  iss_rd;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic [31:0] iss_imm;
  logic        iss_imminstr;

  modport master (
    output in_valid, in_instr, in_alu_ctrl, in_imm_src, in_imminstr,
           in_load_en, in_store_en, in_add_en, in_mul_en,
           ld_ready, st_ready, add_ready, mul_ready,
    input  in_ready, ld_valid, st_valid, add_valid, mul_valid,
           iss_op, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_imminstr
  );

  modport slave (
    input  in_valid, in_instr, in_alu_ctrl, in_imm_src, in_imminstr,
           in_load_en, in_store_en, in_add_en, in_mul_en,
           ld_ready, st_ready, add_ready, mul_ready,
    output in_ready, ld_valid, st_valid, add_valid, mul_valid,
           iss_op, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_imminstr
  );
endinterface

// File: rtl/issue_dispatch.sv
// rtl/issue_dispatch.sv - in-order issue stage feeding the load/store/add/mul reservation stations
module issue_dispatch #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  issue_dispatch_if.slave  bus,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] dropped_cnt,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_LD   = 3'd1,
    CLS_ST   = 3'd2,
    CLS_ADD  = 3'd3,
    CLS_MUL  = 3'd4
  } cls_t;

  logic [31:0] instr_q [DEPTH];
  logic [2:0]  op_q    [DEPTH];
  logic [1:0]  src_q   [DEPTH];
  logic        immi_q  [DEPTH];
  cls_t        cls_q   [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          push;
  logic          pop;
  logic          issue;
  logic          drop;
  cls_t          in_cls;
  cls_t          head_cls;

  // Only a single asserted enable names a station; anything else is never executed.
  always_comb begin
    in_cls = CLS_NONE;
    case ({bus.in_load_en, bus.in_store_en, bus.in_add_en, bus.in_mul_en})
      4'b1000: in_cls = CLS_LD;
      4'b0100: in_cls = CLS_ST;
      4'b0010: in_cls = CLS_ADD;
      4'b0001: in_cls = CLS_MUL;
      default: in_cls = CLS_NONE;
    endcase
  end

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;

  assign head_cls      = cls_q[rd_ptr];
  assign bus.ld_valid  = !empty && (head_cls == CLS_LD);
  assign bus.st_valid  = !empty && (head_cls == CLS_ST);
  assign bus.add_valid = !empty && (head_cls == CLS_ADD);
  assign bus.mul_valid = !empty && (head_cls == CLS_MUL);

  assign issue = (bus.ld_valid  && bus.ld_ready)  ||
                 (bus.st_valid  && bus.st_ready)  ||
                 (bus.add_valid && bus.add_ready) ||
                 (bus.mul_valid && bus.mul_ready);
  assign drop  = !empty && (head_cls == CLS_NONE);
  assign pop   = issue || drop;

  assign bus.iss_op       = op_q[rd_ptr];
  assign bus.iss_rd       = instr_q[rd_ptr][11:7];
  assign bus.iss_rs1      = instr_q[rd_ptr][19:15];
  assign bus.iss_rs2      = instr_q[rd_ptr][24:20];
  assign bus.iss_imminstr = immi_q[rd_ptr];

  always_comb begin
    bus.iss_imm = '0;
    case (src_q[rd_ptr])
      2'b00:   bus.iss_imm = {{20{instr_q[rd_ptr][31]}}, instr_q[rd_ptr][31:20]};
      2'b01:   bus.iss_imm = {{20{instr_q[rd_ptr][31]}}, instr_q[rd_ptr][31:25],
                              instr_q[rd_ptr][11:7]};
      default: bus.iss_imm = '0;
    endcase
  end

  // Storage is cleared on reset so the idle payload outputs are defined values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      issued_cnt  <= '0;
      dropped_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        op_q[i]    <= '0;
        src_q[i]   <= '0;
        immi_q[i]  <= 1'b0;
        cls_q[i]   <= CLS_NONE;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= bus.in_instr;
        op_q[wr_ptr]    <= bus.in_alu_ctrl;
        src_q[wr_ptr]   <= bus.in_imm_src;
        immi_q[wr_ptr]  <= bus.in_imminstr;
        cls_q[wr_ptr]   <= in_cls;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (!push && pop) begin
        count <= count - (AW+1)'(1);
      end
      if (issue) begin
        issued_cnt <= issued_cnt + CNT_W'(1);
      end
      if (drop) begin
        dropped_cnt <= dropped_cnt + CNT_W'(1);
      end
    end
  end
endmodule
